// File: rtl/booth_pkg.sv
// Shared types and width helpers for the iterative radix-4 Booth multiplier.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_e;

    // One extra iteration covers the two extension bits, which keeps unsigned operands exact.
    function automatic int booth_iter(input int width);
        return width / 2 + 1;
    endfunction

    function automatic int booth_cnt_w(input int width);
        return $clog2(booth_iter(width) + 1);
    endfunction

endpackage

// File: rtl/booth_radix4_encoder.sv
// Radix-4 Booth recoder: {b[2i+1], b[2i], b[2i-1]} -> digit in {0, +-1, +-2}.
// Latency: combinational.
// Backpressure: none, pure function of the group.
module booth_radix4_encoder
    import booth_pkg::*;
(
    input  logic [2:0]   grp,
    output booth_digit_e digit,
    output logic         neg
);

    always_comb begin
        digit = ZERO;
        case (grp)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

    assign neg = grp[2] & ~(grp[1] & grp[0]);

endmodule

// File: rtl/booth_radix4_seq_multiplier.sv
// Iterative radix-4 Booth multiplier, signed or unsigned per operation, two bits retired per cycle.
// Latency: WIDTH/2+1 edges from accept to outValid; BOOTH_EARLY_TERM_EN ends CALC once remaining digits are zero.
// Backpressure: result held in DONE until outReady; a new accept may coincide with the result transfer.
module booth_radix4_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               inValid,
    output logic               inReady,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               signedMode,
    output logic               outValid,
    input  logic               outReady,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int ITER = booth_iter(WIDTH);
    localparam int CW   = booth_cnt_w(WIDTH);
    localparam int EW   = WIDTH + 2;
    localparam int HW   = EW + 2;
    localparam int AW   = HW + EW;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, rem;
    logic [EW-1:0]  a_q, b_q, a_in, b_in, b_sh;
    logic           guard_q;
    logic [AW-1:0]  acc_q, acc_sum, acc_sh, acc_d;
    logic [HW-1:0]  a_hw, mag, term;
    logic           accept, last;
    booth_digit_e   digit;
    logic           neg;

    assign a_in = signedMode ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
    assign b_in = signedMode ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};

    booth_radix4_encoder u_enc (
        .grp   ({b_q[1:0], guard_q}),
        .digit (digit),
        .neg   (neg)
    );

    // Partial product is added at the top of the accumulator, then everything shifts right by 2.
    always_comb begin
        a_hw = {{2{a_q[EW-1]}}, a_q};
        mag  = '0;
        case (digit)
            POS1, NEG1: mag = a_hw;
            POS2, NEG2: mag = a_hw << 1;
            default:    mag = '0;
        endcase
        term    = neg ? -mag : mag;
        acc_sum = acc_q + {term, {EW{1'b0}}};
        acc_sh  = $signed(acc_sum) >>> 2;
        b_sh    = $signed(b_q) >>> 2;
        rem     = cnt_q - CW'(1);
`ifdef BOOTH_EARLY_TERM_EN
        // Remaining bits all equal to the guard bit means every later digit is zero.
        if (b_sh == {EW{b_q[1]}}) begin
            acc_d = $signed(acc_sh) >>> {rem, 1'b0};
            last  = 1'b1;
        end else begin
            acc_d = acc_sh;
            last  = (cnt_q == CW'(1));
        end
`else
        acc_d = acc_sh;
        last  = (cnt_q == CW'(1));
`endif
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        inReady  = 1'b0;
        outValid = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) state_d = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                outValid = 1'b1;
                inReady  = outReady;
                if (outReady) state_d = inValid ? CALC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = inValid & inReady;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            a_q     <= '0;
            b_q     <= '0;
            guard_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= a_in;
            b_q     <= b_in;
            guard_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= CW'(ITER);
        end else if (state_q == CALC) begin
            acc_q   <= acc_d;
            b_q     <= b_sh;
            guard_q <= b_q[1];
            cnt_q   <= rem;
        end
    end

    // Gated so that only a finished result is ever visible on the port.
    assign product = (state_q == DONE) ? acc_q[2*WIDTH-1:0] : '0;

endmodule
